// File: rtl/axonerve_wordcount_control_s_axi_if.sv
// rtl/axonerve_wordcount_control_s_axi_if.sv - AXI4-Lite control bus between host and word-count kernel control block
interface axonerve_wordcount_control_s_axi_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axonerve_wordcount_control_s_axi.sv
// rtl/axonerve_wordcount_control_s_axi.sv - AXI4-Lite control registers and ap_ctrl_hs handshake for the word-count kernel
// Optional interrupt logic (GIE/IER/ISR, interrupt output) is built when AXONERVE_CTRL_IRQ_EN is defined.
module axonerve_wordcount_control_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                               ap_clk,
  input  logic                               areset,
  axonerve_wordcount_control_s_axi_if.slave  s_axi_control,
  output logic                               ap_start,
  input  logic                               ap_done,
  input  logic                               ap_idle,
  output logic [31:0]                        data_num,
  output logic [31:0]                        command,
  output logic [63:0]                        axi00_ptr0,
  output logic                               interrupt
);
  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_GIE      = 4'h1;
  localparam logic [3:0] ADDR_IER      = 4'h2;
  localparam logic [3:0] ADDR_ISR      = 4'h3;
  localparam logic [3:0] ADDR_DATA_NUM = 4'h4;
  localparam logic [3:0] ADDR_COMMAND  = 4'h6;
  localparam logic [3:0] ADDR_PTR_LO   = 4'h8;
  localparam logic [3:0] ADDR_PTR_HI   = 4'h9;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_e;
  typedef enum logic       {RIDLE, RDATA}        rstate_e;

  wstate_e                         wstate_q;
  rstate_e                         rstate_q;
  logic                            awready_q;
  logic                            wready_q;
  logic                            bvalid_q;
  logic                            arready_q;
  logic                            rvalid_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [31:0]                     rd_mux;

  logic                            ap_start_q;
  logic                            ap_start_d;
  logic                            ap_done_q;
  logic                            ap_done_d;
  logic                            auto_restart_q;
  logic [31:0]                     data_num_q;
  logic [31:0]                     command_q;
  logic [63:0]                     ptr_q;
  logic                            gie_rd;
  logic                            ier_rd;
  logic                            isr_rd;

  logic                            aw_hs;
  logic                            w_hs;
  logic                            ar_hs;
  logic [3:0]                      waddr_idx;
  logic [3:0]                      raddr_idx;
  logic                            unused_addr_bits;

  // Ready flags are only ever high in their idle/data state, so they double as state qualifiers.
  assign aw_hs     = s_axi_control.awvalid & awready_q;
  assign w_hs      = s_axi_control.wvalid  & wready_q;
  assign ar_hs     = s_axi_control.arvalid & arready_q;
  assign waddr_idx = awaddr_q[5:2];
  assign raddr_idx = s_axi_control.araddr[5:2];
  assign unused_addr_bits = ^{awaddr_q[1:0], s_axi_control.araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate_q  <= WIDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
    end else begin
      case (wstate_q)
        WIDLE: begin
          if (aw_hs) begin
            awaddr_q  <= s_axi_control.awaddr;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= WDATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        WDATA: begin
          if (w_hs) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            wstate_q <= WRESP;
          end
        end
        WRESP: begin
          if (s_axi_control.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= WIDLE;
          end
        end
        default: wstate_q <= WIDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rstate_q  <= RIDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        RIDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_mux;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rstate_q  <= RDATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RDATA: begin
          if (s_axi_control.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= RIDLE;
          end
        end
        default: rstate_q <= RIDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (raddr_idx)
      ADDR_CTRL:     rd_mux[7:0] = {auto_restart_q, 4'b0000, ap_idle, ap_done_q, ap_start_q};
      ADDR_GIE:      rd_mux[0]   = gie_rd;
      ADDR_IER:      rd_mux[0]   = ier_rd;
      ADDR_ISR:      rd_mux[0]   = isr_rd;
      ADDR_DATA_NUM: rd_mux      = data_num_q;
      ADDR_COMMAND:  rd_mux      = command_q;
      ADDR_PTR_LO:   rd_mux      = ptr_q[31:0];
      ADDR_PTR_HI:   rd_mux      = ptr_q[63:32];
      default:       rd_mux      = '0;
    endcase
  end

  // A start write in the same cycle as ap_done wins; a done pulse racing the status read keeps the bit set.
  always_comb begin
    ap_start_d = ap_start_q;
    if (ap_done && !auto_restart_q) ap_start_d = 1'b0;
    if (w_hs && waddr_idx == ADDR_CTRL && s_axi_control.wstrb[0] && s_axi_control.wdata[0])
      ap_start_d = 1'b1;
    ap_done_d = ap_done_q;
    if (ar_hs && raddr_idx == ADDR_CTRL) ap_done_d = 1'b0;
    if (ap_done) ap_done_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_q     <= 1'b0;
      ap_done_q      <= 1'b0;
      auto_restart_q <= 1'b0;
      data_num_q     <= '0;
      command_q      <= '0;
      ptr_q          <= '0;
    end else begin
      ap_start_q <= ap_start_d;
      ap_done_q  <= ap_done_d;
      if (w_hs) begin
        case (waddr_idx)
          ADDR_CTRL:     if (s_axi_control.wstrb[0]) auto_restart_q <= s_axi_control.wdata[7];
          ADDR_DATA_NUM: data_num_q   <= merge_bytes(data_num_q, s_axi_control.wdata, s_axi_control.wstrb);
          ADDR_COMMAND:  command_q    <= merge_bytes(command_q, s_axi_control.wdata, s_axi_control.wstrb);
          ADDR_PTR_LO:   ptr_q[31:0]  <= merge_bytes(ptr_q[31:0], s_axi_control.wdata, s_axi_control.wstrb);
          ADDR_PTR_HI:   ptr_q[63:32] <= merge_bytes(ptr_q[63:32], s_axi_control.wdata, s_axi_control.wstrb);
          default: ;
        endcase
      end
    end
  end

`ifdef AXONERVE_CTRL_IRQ_EN
  logic gie_q;
  logic gie_d;
  logic ier_q;
  logic ier_d;
  logic isr_q;
  logic isr_d;
  logic irq_q;

  always_comb begin
    gie_d = gie_q;
    ier_d = ier_q;
    isr_d = isr_q;
    if (w_hs && s_axi_control.wstrb[0]) begin
      case (waddr_idx)
        ADDR_GIE: gie_d = s_axi_control.wdata[0];
        ADDR_IER: ier_d = s_axi_control.wdata[0];
        ADDR_ISR: isr_d = isr_q ^ s_axi_control.wdata[0];
        default: ;
      endcase
    end
    if (ap_done && ier_q) isr_d = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      gie_q <= 1'b0;
      ier_q <= 1'b0;
      isr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      gie_q <= gie_d;
      ier_q <= ier_d;
      isr_q <= isr_d;
      irq_q <= gie_d & isr_d;
    end
  end

  assign gie_rd    = gie_q;
  assign ier_rd    = ier_q;
  assign isr_rd    = isr_q;
  assign interrupt = irq_q;
`else
  assign gie_rd    = 1'b0;
  assign ier_rd    = 1'b0;
  assign isr_rd    = 1'b0;
  assign interrupt = 1'b0;
`endif

  assign s_axi_control.awready = awready_q;
  assign s_axi_control.wready  = wready_q;
  assign s_axi_control.bvalid  = bvalid_q;
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = arready_q;
  assign s_axi_control.rvalid  = rvalid_q;
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = 2'b00;

  assign ap_start   = ap_start_q;
  assign data_num   = data_num_q;
  assign command    = command_q;
  assign axi00_ptr0 = ptr_q;
endmodule
